// File: rtl/fa_response_checker.sv
// Response checker for a full-adder self-test: accepts {a,b,cin} vectors, waits for the DUT
// to settle, compares sum/cout against a+b+cin and accumulates pass/fail/coverage statistics.
module fa_response_checker #(
  parameter int CNT_W      = 16,
  parameter int NUM_VEC    = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_cin,
  input  logic             obs_sum,
  input  logic             obs_cout,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [7:0]       cov_mask,
  output logic             first_fail_vld,
  output logic [4:0]       first_fail_vec
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0]  SC_LOAD = SC_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] NV      = CNT_W'(NUM_VEC);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        vec_q, vec_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [CNT_W-1:0]  chk_q, chk_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  fail_q, fail_d;
  logic [7:0]        cov_q, cov_d;
  logic              ffv_q, ffv_d;
  logic [4:0]        ffvec_q, ffvec_d;
  logic [1:0]        exp_sum;
  logic              match;
  logic              clr;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    sc_d     = sc_q;
    chk_d    = chk_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    cov_d    = cov_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    clr      = 1'b0;
    exp_sum  = 2'(vec_q[2]) + 2'(vec_q[1]) + 2'(vec_q[0]);
    match    = ({obs_cout, obs_sum} == exp_sum);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          vec_d   = {in_a, in_b, in_cin};
          sc_d    = SC_LOAD;
          state_d = (SETTLE_CYC == 0) ? S_CHECK : S_SETTLE;
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (sc_q == '0) state_d = S_CHECK;
        else            sc_d    = sc_q - 1'b1;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (match) begin
          if (pass_q != '1) pass_d = pass_q + 1'b1;
        end else begin
          if (fail_q != '1) fail_d = fail_q + 1'b1;
          // Only the first mismatch of a run is captured for debug.
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = {vec_q, obs_sum, obs_cout};
          end
        end
        cov_d[vec_q] = 1'b1;
        chk_d        = chk_q + 1'b1;
        state_d      = (chk_d == NV) ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          clr     = 1'b1;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clr) begin
      chk_d   = '0;
      pass_d  = '0;
      fail_d  = '0;
      cov_d   = '0;
      ffv_d   = 1'b0;
      ffvec_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      sc_q    <= '0;
      chk_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      cov_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      sc_q    <= sc_d;
      chk_q   <= chk_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      cov_q   <= cov_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign cov_mask       = cov_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_vec = ffvec_q;
  assign all_pass       = done && (fail_q == '0) && (cov_q == 8'hFF);

endmodule

// File: tb/tb_fa_response_checker.sv
// Randomized bench for fa_response_checker: an emulated full-adder DUT answers only in the
// expected CHECK cycle, and a run-level statistics model predicts every counter and flag.
module tb_fa_response_checker;
  localparam int NV = 8;
  localparam int SC = 2;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic        in_a = 1'b0, in_b = 1'b0, in_cin = 1'b0, obs_sum = 1'b0, obs_cout = 1'b0;
  logic        in_ready, busy, done, all_pass, first_fail_vld;
  logic [15:0] pass_cnt, fail_cnt;
  logic [7:0]  cov_mask;
  logic [4:0]  first_fail_vec;

  fa_response_checker #(.CNT_W(16), .NUM_VEC(NV), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .obs_sum(obs_sum), .obs_cout(obs_cout),
    .busy(busy), .done(done), .all_pass(all_pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .cov_mask(cov_mask), .first_fail_vld(first_fail_vld), .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int pass_m, fail_m, chk_m, lat_bad;
  logic [7:0] cov_m;
  logic       ffv_m;
  logic [4:0] ffvec_m;

  wire [47:0] stats = {pass_cnt, fail_cnt, cov_mask, first_fail_vld, first_fail_vec,
                       done, all_pass};

  function automatic logic [47:0] model_stats();
    logic d;
    d = (chk_m == NV);
    return {16'(pass_m), 16'(fail_m), cov_m, ffv_m, ffvec_m, d,
            d && fail_m == 0 && cov_m == 8'hFF};
  endfunction

  task automatic clear_model();
    pass_m = 0; fail_m = 0; chk_m = 0; cov_m = '0; ffv_m = 1'b0; ffvec_m = '0; lat_bad = 0;
  endtask

  // Tasks start and end 1 time unit after a rising edge.
  task automatic pulse_start(input bit accepted);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (accepted) clear_model();
  endtask

  // fault: 0 golden adder, 1 sum stuck-at-0, 2 random corruption of one or both outputs.
  task automatic send(input logic [2:0] v, input int fault, input int gap);
    bit got;
    logic [1:0] expv, obs;
    repeat (gap) begin in_valid = 1'b0; @(posedge clk); #1; end
    {in_a, in_b, in_cin} = v;
    in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin lat_bad++; in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    {in_a, in_b, in_cin} = 3'($urandom);
    repeat (SC) begin
      @(negedge clk);
      if (in_ready || !busy) lat_bad++;
      @(posedge clk); #1;
    end
    expv = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
    obs = expv;
    if (fault == 1) obs[0] = 1'b0;
    if (fault == 2) obs = obs ^ 2'($urandom_range(1, 3));
    {obs_cout, obs_sum} = obs;
    @(negedge clk);
    if (in_ready || !busy) lat_bad++;
    @(posedge clk); #1;
    {obs_cout, obs_sum} = 2'($urandom);
    chk_m++;
    cov_m[v] = 1'b1;
    if (obs == expv) pass_m++;
    else begin
      fail_m++;
      if (!ffv_m) begin ffv_m = 1'b1; ffvec_m = {v, obs[0], obs[1]}; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if ({stats, busy, in_ready} !== '0) begin
      n_fail++; $display("FAIL reset_state got=%h busy=%b rdy=%b exp=0", stats, busy, in_ready);
    end
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    clear_model();
  endtask

  task automatic test_golden();
    pulse_start(1);
    for (int v = 0; v < 8; v++) send(3'(v), 0, 0);
    @(negedge clk);
    n_tests++;
    if (stats !== model_stats()) begin
      n_fail++; $display("FAIL golden_stats got=%h exp=%h", stats, model_stats());
    end
    n_tests++;
    if ({pass_cnt, fail_cnt, cov_mask, all_pass, first_fail_vld, busy, lat_bad[0]} !==
        {16'd8, 16'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0} || lat_bad != 0) begin
      n_fail++;
      $display("FAIL golden_const pass=%0d fail=%0d cov=%h ap=%b ffv=%b busy=%b lat=%0d",
               pass_cnt, fail_cnt, cov_mask, all_pass, first_fail_vld, busy, lat_bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stuck();
    pulse_start(1);
    for (int v = 0; v < 8; v++) send(3'(v), 1, 0);
    @(negedge clk);
    n_tests++;
    if (stats !== model_stats()) begin
      n_fail++; $display("FAIL stuck_stats got=%h exp=%h", stats, model_stats());
    end
    n_tests++;
    if ({fail_cnt, pass_cnt, first_fail_vec, all_pass, done} !==
        {16'd4, 16'd4, 5'b00100, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL stuck_const fail=%0d pass=%0d ffvec=%b ap=%b done=%b",
               fail_cnt, pass_cnt, first_fail_vec, all_pass, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_throttled();
    pulse_start(1);
    for (int v = 7; v >= 0; v--) send(3'(v), 0, 2);
    @(negedge clk);
    n_tests++;
    if (stats !== model_stats() || all_pass !== 1'b1) begin
      n_fail++; $display("FAIL throttled_stats got=%h exp=%h", stats, model_stats());
    end
    n_tests++;
    if (lat_bad != 0) begin
      n_fail++; $display("FAIL throttled_timing violations=%0d exp=0", lat_bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_duplicates();
    pulse_start(1);
    for (int i = 0; i < 8; i++) send(3'b000, 0, $urandom_range(0, 1));
    @(negedge clk);
    n_tests++;
    if (stats !== model_stats()) begin
      n_fail++; $display("FAIL dup_stats got=%h exp=%h", stats, model_stats());
    end
    n_tests++;
    if ({pass_cnt, cov_mask, done, all_pass} !== {16'd8, 8'h01, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL dup_const pass=%0d cov=%h done=%b ap=%b", pass_cnt, cov_mask, done, all_pass);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bit rdy_seen;
    pulse_start(1);
    for (int i = 0; i < 3; i++) send(3'($urandom), 2, 0);
    {in_a, in_b, in_cin} = 3'b101;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({stats, busy, in_ready} !== '0) begin
      n_fail++; $display("FAIL midreset_clear got=%h busy=%b rdy=%b exp=0", stats, busy, in_ready);
    end
    rdy_seen = 0;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (in_ready || busy) rdy_seen = 1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (rdy_seen) begin
      n_fail++; $display("FAIL midreset_idle in_ready/busy=1 exp=0 without start");
    end
    pulse_start(1);
    for (int v = 0; v < 8; v++) send(3'(v), 0, 0);
    @(negedge clk);
    n_tests++;
    if (stats !== model_stats() || all_pass !== 1'b1) begin
      n_fail++; $display("FAIL midreset_rerun got=%h exp=%h", stats, model_stats());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_handling();
    logic [47:0] held;
    pulse_start(1);
    for (int i = 0; i < 3; i++) send(3'($urandom), 2 * $urandom_range(0, 1), 0);
    pulse_start(0);
    for (int i = 0; i < 5; i++) send(3'($urandom), 2 * $urandom_range(0, 1), 0);
    @(negedge clk);
    n_tests++;
    if (stats !== model_stats() || done !== 1'b1) begin
      n_fail++; $display("FAIL start_ignored got=%h exp=%h", stats, model_stats());
    end
    held = model_stats();
    in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stats !== held || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL done_hold got=%h exp=%h rdy=%b", stats, held, in_ready);
    end
    @(posedge clk); #1;
    pulse_start(1);
    @(negedge clk);
    n_tests++;
    if ({stats, busy, in_ready} !== {48'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL restart_clear got=%h busy=%b rdy=%b", stats, busy, in_ready);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(3'($urandom), 2 * $urandom_range(0, 1), 0);
    @(negedge clk);
    n_tests++;
    if (stats !== model_stats()) begin
      n_fail++; $display("FAIL restart_run got=%h exp=%h", stats, model_stats());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      pulse_start(1);
      for (int i = 0; i < 8; i++)
        send(3'($urandom), 2 * $urandom_range(0, 1), $urandom_range(0, 3));
      @(negedge clk);
      n_tests++;
      if (stats !== model_stats() || lat_bad != 0) begin
        n_fail++;
        $display("FAIL random_run%0d got=%h exp=%h lat=%0d", r, stats, model_stats(), lat_bad);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_golden();
    test_stuck();
    test_throttled();
    test_duplicates();
    test_mid_reset();
    test_start_handling();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
